out_feature_writer: RTL and testbench

OUT_FEATURE_WRITER -- requirements
Module: out_feature_writer

---
 rtl/out_feature_writer_if.sv | 44 ++++
 rtl/out_feature_writer.sv | 134 +++++++++++++
 tb/tb_out_feature_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_feature_writer_if.sv
// Bundle between the convolution controller and the output feature writer:
// accumulator sums in, M9K write port and progress status out.
interface out_feature_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 7
);

  logic                          start;
  logic                          accum_sload;
  logic [LANES*ACC_WIDTH-1:0]    accum_result_all;

  logic                          out_feature_wren;
  logic [ADDR_WIDTH-1:0]         out_feature_addr;
  logic [LANES*DATA_WIDTH-1:0]   out_feature_data_all;
  logic [ADDR_WIDTH:0]           write_count;
  logic                          write_done;

  // Controller / producer side
  modport master (
    output start,
    output accum_sload,
    output accum_result_all,
    input  out_feature_wren,
    input  out_feature_addr,
    input  out_feature_data_all,
    input  write_count,
    input  write_done
  );

  // Writer side
  modport slave (
    input  start,
    input  accum_sload,
    input  accum_result_all,
    output out_feature_wren,
    output out_feature_addr,
    output out_feature_data_all,
    output write_count,
    output write_done
  );

endinterface

// File: rtl/out_feature_writer.sv
// Output feature writer: captures each finished accumulator sum, quantizes
// every lane to DATA_WIDTH with saturation, and writes one word per address
// into the output feature M9K until TOTAL addresses have been filled.
//
//   state | meaning
//   IDLE  | waiting for start from the conv controller
//   SKIP  | first sload carries no valid sum; drop it
//   RUN   | every sload captures a sum and writes it the next cycle
//   DONE  | all TOTAL words written; sloads ignored until reset
module out_feature_writer #(
  parameter int DATA_WIDTH        = 16,
  parameter int ACC_WIDTH         = 36,
  parameter int LANES             = 4,
  parameter int FRAC_SHIFT        = 8,
  parameter int OUT_FEATURE_WIDTH = 8,
  parameter int NUM_ONEMULT       = 2,
  parameter int ADDR_WIDTH        = 7
) (
  input  logic                clock_i,
  input  logic                reset_i,
  out_feature_writer_if.slave bus
);

  localparam int TOTAL = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);

  // Saturation bounds expressed at accumulator width so the compare is exact.
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN =
    ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      state_q, state_d;

  logic                        wren_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [ADDR_WIDTH:0]         count_q;
  logic                        done_q;
  logic [LANES*DATA_WIDTH-1:0] data_q;

  logic                        capture_en;
  logic                        last_write;
  logic [LANES*DATA_WIDTH-1:0] quant_all;

  // Arithmetic shift then clamp into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [ACC_WIDTH-1:0] res);
    logic signed [ACC_WIDTH-1:0] v;
    v = $signed(res) >>> FRAC_SHIFT;
    if (v > Q_MAX) begin
      return Q_MAX[DATA_WIDTH-1:0];
    end else if (v < Q_MIN) begin
      return Q_MIN[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  // Per-lane quantization of the incoming sums, ready to be captured.
  always_comb begin
    quant_all = '0;
    for (int i = 0; i < LANES; i++) begin
      quant_all[i*DATA_WIDTH +: DATA_WIDTH] =
        quantize(bus.accum_result_all[i*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start dropping later never aborts, only reset does.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)       state_d = S_SKIP;
      S_SKIP:  if (bus.accum_sload) state_d = S_RUN;
      S_RUN:   if (last_write)      state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the final write cycle blocks any coincident capture so
  // nothing is lost past the last address.
  always_comb begin
    last_write = wren_q && (addr_q == LAST_ADDR);
    capture_en = (state_q == S_RUN) && bus.accum_sload && !last_write;
  end

  // Capture, write strobe, address/count progression and completion flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wren_q  <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      wren_q <= capture_en;
      if (capture_en) begin
        data_q <= quant_all;
      end
      if (wren_q) begin
        count_q <= count_q + 1'b1;
        if (addr_q != LAST_ADDR) begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (last_write) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bus.out_feature_wren     = wren_q;
  assign bus.out_feature_addr     = addr_q;
  assign bus.out_feature_data_all = data_q;
  assign bus.write_count          = count_q;
  assign bus.write_done           = done_q;

endmodule

// File: tb/tb_out_feature_writer.sv
// Directed bench for out_feature_writer: reset, pre-start pulses, skip,
// saturation, back-to-back, full 128-word run, overrun and mid-run reset.
module tb_out_feature_writer;

  localparam int DW  = 16;
  localparam int AW  = 36;
  localparam int L   = 4;
  localparam int ADW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  out_feature_writer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L), .ADDR_WIDTH(ADW)) bus ();

  out_feature_writer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L), .FRAC_SHIFT(8),
    .OUT_FEATURE_WIDTH(8), .NUM_ONEMULT(2), .ADDR_WIDTH(ADW)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane i of word n carries integer (4n+i) plus a fraction that must be dropped.
  function automatic logic [L*AW-1:0] mk_res(input int n);
    logic [L*AW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[i*AW +: AW] = AW'(((n*4 + i) << 8) + 127);
    return r;
  endfunction

  function automatic logic [L*DW-1:0] exp_data(input int n);
    logic [L*DW-1:0] d;
    d = '0;
    for (int i = 0; i < L; i++) d[i*DW +: DW] = DW'(n*4 + i);
    return d;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sload_once(input logic [L*AW-1:0] r);
    bus.accum_result_all = r;
    bus.accum_sload      = 1'b1;
    @(negedge clk);
    bus.accum_sload      = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_wren"},  64'(bus.out_feature_wren), 64'd0);
    check({pfx, "_addr"},  64'(bus.out_feature_addr), 64'd0);
    check({pfx, "_data"},  64'(bus.out_feature_data_all), 64'd0);
    check({pfx, "_count"}, 64'(bus.write_count), 64'd0);
    check({pfx, "_done"},  64'(bus.write_done), 64'd0);
    check({pfx, "_state"}, 64'(dut.state_q), 64'd0);
  endtask

  logic [L*AW-1:0] sat_res;

  initial begin
    bus.start            = 1'b0;
    bus.accum_sload      = 1'b0;
    bus.accum_result_all = '0;

    // Reset state
    idle(2);
    check_zero("reset");
    rst = 1'b0;
    idle(1);

    // Pulses before start are ignored
    repeat (3) begin
      sload_once(mk_res(5));
      check("prestart_wren", 64'(bus.out_feature_wren), 64'd0);
      idle(2);
    end
    check("prestart_addr",  64'(bus.out_feature_addr), 64'd0);
    check("prestart_data",  64'(bus.out_feature_data_all), 64'd0);
    check("prestart_state", 64'(dut.state_q), 64'd0);

    // Start -> SKIP, first sload dropped
    bus.start = 1'b1;
    step();
    check("skip_state", 64'(dut.state_q), 64'd1);
    sload_once(mk_res(99));
    check("skip_wren", 64'(bus.out_feature_wren), 64'd0);
    check("skip_data", 64'(bus.out_feature_data_all), 64'd0);
    idle(8);
    check("run_state", 64'(dut.state_q), 64'd2);

    // Saturation vector at address 0
    sat_res = '0;
    sat_res[0*AW +: AW] = 36'h0_4000_0000;
    sat_res[1*AW +: AW] = 36'hF_C000_0000;
    sat_res[2*AW +: AW] = 36'h0_0000_1234;
    sat_res[3*AW +: AW] = 36'hF_FFFF_FFFF;
    sload_once(sat_res);
    check("sat_wren", 64'(bus.out_feature_wren), 64'd1);
    check("sat_addr", 64'(bus.out_feature_addr), 64'd0);
    check("sat_data", 64'(bus.out_feature_data_all), 64'hFFFF_0012_8000_7FFF);
    step();
    check("sat_wren_drop", 64'(bus.out_feature_wren), 64'd0);
    check("sat_data_hold", 64'(bus.out_feature_data_all), 64'hFFFF_0012_8000_7FFF);
    check("sat_addr_inc",  64'(bus.out_feature_addr), 64'd1);
    check("sat_count",     64'(bus.write_count), 64'd1);
    idle(7);

    // Back-to-back sloads with start dropped
    bus.start            = 1'b0;
    bus.accum_result_all = mk_res(1);
    bus.accum_sload      = 1'b1;
    step();
    check("b2b1_wren", 64'(bus.out_feature_wren), 64'd1);
    check("b2b1_addr", 64'(bus.out_feature_addr), 64'd1);
    check("b2b1_data", 64'(bus.out_feature_data_all), 64'(exp_data(1)));
    bus.accum_result_all = mk_res(2);
    step();
    check("b2b2_wren", 64'(bus.out_feature_wren), 64'd1);
    check("b2b2_addr", 64'(bus.out_feature_addr), 64'd2);
    check("b2b2_data", 64'(bus.out_feature_data_all), 64'(exp_data(2)));
    bus.accum_result_all = mk_res(3);
    step();
    check("b2b3_wren", 64'(bus.out_feature_wren), 64'd1);
    check("b2b3_addr", 64'(bus.out_feature_addr), 64'd3);
    check("b2b3_data", 64'(bus.out_feature_data_all), 64'(exp_data(3)));
    bus.accum_sload = 1'b0;
    step();
    check("b2b_end_wren",  64'(bus.out_feature_wren), 64'd0);
    check("b2b_end_count", 64'(bus.write_count), 64'd4);
    check("b2b_end_addr",  64'(bus.out_feature_addr), 64'd4);
    idle(7);

    // Nominal spaced writes up to address 126
    for (int n = 4; n < 127; n++) begin
      sload_once(mk_res(n));
      check("run_wren", 64'(bus.out_feature_wren), 64'd1);
      check("run_addr", 64'(bus.out_feature_addr), 64'(n));
      check("run_data", 64'(bus.out_feature_data_all), 64'(exp_data(n)));
      idle(8);
    end

    // Final write with a coincident sload
    sload_once(mk_res(127));
    check("last_wren",  64'(bus.out_feature_wren), 64'd1);
    check("last_addr",  64'(bus.out_feature_addr), 64'd127);
    check("last_done",  64'(bus.write_done), 64'd0);
    check("last_count", 64'(bus.write_count), 64'd127);
    bus.accum_result_all = mk_res(200);
    bus.accum_sload      = 1'b1;
    step();
    bus.accum_sload      = 1'b0;
    check("coinc_wren",  64'(bus.out_feature_wren), 64'd0);
    check("done_flag",   64'(bus.write_done), 64'd1);
    check("done_count",  64'(bus.write_count), 64'd128);
    check("done_addr",   64'(bus.out_feature_addr), 64'd127);
    check("done_data",   64'(bus.out_feature_data_all), 64'(exp_data(127)));
    check("done_state",  64'(dut.state_q), 64'd3);

    // Overrun pulses after completion
    repeat (5) begin
      sload_once(mk_res(300));
      check("overrun_wren", 64'(bus.out_feature_wren), 64'd0);
      idle(3);
    end
    check("overrun_addr",  64'(bus.out_feature_addr), 64'd127);
    check("overrun_count", 64'(bus.write_count), 64'd128);
    check("overrun_done",  64'(bus.write_done), 64'd1);
    check("overrun_data",  64'(bus.out_feature_data_all), 64'(exp_data(127)));

    // Fresh run, then reset after address 40 has been written
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    sload_once(mk_res(50));
    check("rerun_skip_wren", 64'(bus.out_feature_wren), 64'd0);
    idle(2);
    for (int n = 0; n <= 40; n++) begin
      sload_once(mk_res(n));
      check("rerun_addr", 64'(bus.out_feature_addr), 64'(n));
    end
    step();
    check("prereset_addr",  64'(bus.out_feature_addr), 64'd41);
    check("prereset_count", 64'(bus.write_count), 64'd41);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    sload_once(mk_res(7));
    check("restart_skip_wren", 64'(bus.out_feature_wren), 64'd0);
    idle(3);
    sload_once(mk_res(8));
    check("restart_wren", 64'(bus.out_feature_wren), 64'd1);
    check("restart_addr", 64'(bus.out_feature_addr), 64'd0);
    check("restart_data", 64'(bus.out_feature_data_all), 64'(exp_data(8)));
    step();
    check("restart_count", 64'(bus.write_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
